// File: rtl/sse_ctrl_pkg.sv
// Shared definitions for the SSE stream controller: FSM state encoding and
// the reserved command/ack byte values.
package sse_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_SELECT,
        ST_RUN,
        ST_DRAIN,
        ST_ACK
    } state_t;

    localparam logic [7:0] CMD_RESET = 8'hFF;
    localparam logic [7:0] ACK_ERR   = 8'hEE;

endpackage

// File: rtl/sse_frame_counter.sv
// Saturating pixel counter with synchronous clear and a terminal-count flag;
// it stops incrementing once it reaches TC_VALUE.
module sse_frame_counter #(
    parameter int             W        = 20,
    parameter logic [W-1:0]   TC_VALUE = '1
) (
    input  logic         bus_clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == TC_VALUE);

    // NOTE: registered state is always updated with non-blocking assignments.
    always_ff @(posedge bus_clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sse_stream_ctrl.sv
// Command/frame sequencer between the host FIFOs and the SSE pipeline.
// Optional drain watchdog enabled by defining SSE_CTRL_TIMEOUT_EN.
module sse_stream_ctrl
    import sse_ctrl_pkg::*;
#(
    parameter int FRAME_PIXELS   = 307200,
    parameter int PIX_CNT_W      = 20,
    parameter int RST_CYCLES     = 4
`ifdef SSE_CTRL_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 65536
`endif
) (
    input  logic       bus_clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_rd_en,
    output logic       sse_reset,
    output logic       sse_select_valid,
    input  logic       sse_select_ready,
    output logic [7:0] sse_select_bits,
    input  logic       img_in_valid,
    output logic       img_in_rd_en,
    output logic       sse_img_in_valid,
    input  logic       sse_img_in_ready,
    input  logic       img_out_fire,
    input  logic       ack_full,
    output logic       ack_wr_en,
    output logic [7:0] ack_data,
    output logic       busy,
    output logic [7:0] cur_select
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t           state, next_state;
    logic             cfg_ok;
    logic [7:0]       sel_q, ack_q, ack_val;
    logic [RST_W-1:0] rst_cnt;
    logic             load_sel, load_ack, commit_sel, cnt_clear, in_inc, out_inc;
    logic             in_tc, out_tc;
    logic [PIX_CNT_W-1:0] in_cnt, out_cnt;
    logic             drain_tc;

    sse_frame_counter #(
        .W        (PIX_CNT_W),
        .TC_VALUE (PIX_CNT_W'(FRAME_PIXELS - 1))
    ) u_in_cnt (
        .bus_clk (bus_clk),
        .clear   (reset | cnt_clear),
        .inc     (in_inc),
        .count   (in_cnt),
        .tc      (in_tc)
    );

    // Output beats past the end of the frame saturate here and are ignored.
    sse_frame_counter #(
        .W        (PIX_CNT_W),
        .TC_VALUE (PIX_CNT_W'(FRAME_PIXELS))
    ) u_out_cnt (
        .bus_clk (bus_clk),
        .clear   (reset | cnt_clear),
        .inc     (out_inc),
        .count   (out_cnt),
        .tc      (out_tc)
    );

`ifdef SSE_CTRL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] drain_cnt;

    assign drain_tc = (drain_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge bus_clk) begin
        if (reset || state != ST_DRAIN) drain_cnt <= '0;
        else                            drain_cnt <= drain_cnt + 1'b1;
    end
`else
    assign drain_tc = 1'b0;
`endif

    always_ff @(posedge bus_clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge bus_clk) begin
        if (reset || state != ST_RESET) rst_cnt <= '0;
        else                            rst_cnt <= rst_cnt + 1'b1;
    end

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            cfg_ok     <= 1'b0;
            cur_select <= 8'h00;
            sel_q      <= 8'h00;
            ack_q      <= 8'h00;
        end else begin
            if (load_sel) sel_q <= cmd_data;
            if (load_ack) ack_q <= ack_val;
            if (commit_sel) begin
                cur_select <= sel_q;
                cfg_ok     <= 1'b1;
            end
            if (state == ST_RESET) cfg_ok <= 1'b0;
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        next_state       = state;
        cmd_rd_en        = 1'b0;
        sse_reset        = 1'b0;
        sse_select_valid = 1'b0;
        sse_select_bits  = 8'h00;
        img_in_rd_en     = 1'b0;
        sse_img_in_valid = 1'b0;
        ack_wr_en        = 1'b0;
        ack_data         = 8'h00;
        busy             = (state != ST_IDLE);
        load_sel         = 1'b0;
        load_ack         = 1'b0;
        ack_val          = ack_q;
        commit_sel       = 1'b0;
        cnt_clear        = 1'b0;
        in_inc           = 1'b0;
        out_inc          = 1'b0;

        case (state)
            ST_IDLE: begin
                // A pending command always wins over starting another frame.
                cmd_rd_en = cmd_valid;
                if (cmd_valid) begin
                    load_ack = 1'b1;
                    ack_val  = cmd_data;
                    if (cmd_data == CMD_RESET) begin
                        next_state = ST_RESET;
                    end else begin
                        load_sel   = 1'b1;
                        next_state = ST_SELECT;
                    end
                end else if (cfg_ok && img_in_valid) begin
                    load_ack   = 1'b1;
                    ack_val    = cur_select;
                    next_state = ST_RUN;
                end
            end
            ST_RESET: begin
                sse_reset = 1'b1;
                cnt_clear = 1'b1;
                if (rst_cnt == RST_W'(RST_CYCLES - 1)) next_state = ST_ACK;
            end
            ST_SELECT: begin
                sse_select_valid = 1'b1;
                sse_select_bits  = sel_q;
                if (sse_select_ready) begin
                    commit_sel = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                sse_img_in_valid = img_in_valid;
                img_in_rd_en     = img_in_valid & sse_img_in_ready;
                in_inc           = img_in_rd_en;
                out_inc          = img_out_fire;
                if (img_in_rd_en && in_tc) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_inc = img_out_fire;
                if (out_tc) begin
                    next_state = ST_ACK;
                end else if (drain_tc) begin
                    load_ack   = 1'b1;
                    ack_val    = ACK_ERR;
                    next_state = ST_RESET;
                end
            end
            ST_ACK: begin
                ack_data = ack_q;
                if (!ack_full) begin
                    ack_wr_en  = 1'b1;
                    cnt_clear  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase

        if (reset) begin
            cmd_rd_en        = 1'b0;
            sse_reset        = 1'b1;
            sse_select_valid = 1'b0;
            sse_select_bits  = 8'h00;
            img_in_rd_en     = 1'b0;
            sse_img_in_valid = 1'b0;
            ack_wr_en        = 1'b0;
            ack_data         = 8'h00;
            busy             = 1'b0;
        end
    end

endmodule

// File: tb/tb_sse_stream_ctrl.sv
// Randomized bench for sse_stream_ctrl: FIFO/SSE environment models plus a
// frame-level expectation model (configured flag, current select, ack order).
module tb_sse_stream_ctrl;

    localparam int FP  = 16;
    localparam int RST = 4;
    localparam int TO  = 64;

    logic       bus_clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_rd_en;
    logic       sse_reset;
    logic       sse_select_valid;
    logic       sse_select_ready;
    logic [7:0] sse_select_bits;
    logic       img_in_valid;
    logic       img_in_rd_en;
    logic       sse_img_in_valid;
    logic       sse_img_in_ready;
    logic       img_out_fire;
    logic       ack_full;
    logic       ack_wr_en;
    logic [7:0] ack_data;
    logic       busy;
    logic [7:0] cur_select;

    always #5 bus_clk = ~bus_clk;

    sse_stream_ctrl #(
        .FRAME_PIXELS   (FP),
        .PIX_CNT_W      (20),
        .RST_CYCLES     (RST)
`ifdef SSE_CTRL_TIMEOUT_EN
       ,.TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .bus_clk          (bus_clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_data         (cmd_data),
        .cmd_rd_en        (cmd_rd_en),
        .sse_reset        (sse_reset),
        .sse_select_valid (sse_select_valid),
        .sse_select_ready (sse_select_ready),
        .sse_select_bits  (sse_select_bits),
        .img_in_valid     (img_in_valid),
        .img_in_rd_en     (img_in_rd_en),
        .sse_img_in_valid (sse_img_in_valid),
        .sse_img_in_ready (sse_img_in_ready),
        .img_out_fire     (img_out_fire),
        .ack_full         (ack_full),
        .ack_wr_en        (ack_wr_en),
        .ack_data         (ack_data),
        .busy             (busy),
        .cur_select       (cur_select)
    );

    int checks = 0;
    int errors = 0;

    // Environment state.
    logic [7:0] cmd_q[$];
    int pending, outstanding, emitted, budget;
    int pix_total, cyc, rst_run, rst_rise_cyc, last_pop_cyc, ack_cyc, pending_at_ack, viol;
    logic [7:0] ack_log[$];
    logic [7:0] sel_log[$];
    int pulse_log[$];
    int cmd_pop_cyc[$];
    bit force_full, rand_full;
    logic rst_prev;

    // Frame-level expectation model.
    bit         model_cfg;
    logic [7:0] model_cur;

    task automatic refresh();
        cmd_valid = (cmd_q.size() > 0);
        cmd_data  = cmd_valid ? cmd_q[0] : 8'h00;
        if (pending == 0) img_in_valid = 1'b0;
    endtask

    task automatic clear_logs();
        ack_log.delete();
        sel_log.delete();
        pulse_log.delete();
        cmd_pop_cyc.delete();
    endtask

    // One clock: sample DUT at negedge, apply FIFO/SSE effects after posedge.
    task automatic step();
        logic pop_cmd, pop_img, acc, fire, rst_s;
        @(negedge bus_clk);
        cyc++;
        pop_cmd = cmd_rd_en;
        pop_img = img_in_rd_en;
        acc     = sse_img_in_valid & sse_img_in_ready;
        fire    = img_out_fire;
        rst_s   = sse_reset;
        if (ack_wr_en) begin
            ack_log.push_back(ack_data);
            ack_cyc        = cyc;
            pending_at_ack = pending;
            if (ack_full) viol++;
        end
        if (sse_select_valid && sse_select_ready) sel_log.push_back(sse_select_bits);
        if (sse_reset) rst_run++;
        else if (rst_run > 0) begin
            pulse_log.push_back(rst_run);
            rst_run = 0;
        end
        if (sse_reset && !rst_prev) rst_rise_cyc = cyc;
        rst_prev = sse_reset;
        if (img_in_rd_en && !(img_in_valid && sse_img_in_ready)) viol++;
        if (sse_img_in_valid && !img_in_valid) viol++;
        if (pop_cmd && !cmd_valid) viol++;
        if (pop_cmd) cmd_pop_cyc.push_back(cyc);
        if (pop_img) begin
            last_pop_cyc = cyc;
            pix_total++;
        end
        @(posedge bus_clk);
        #1;
        if (pop_cmd) void'(cmd_q.pop_front());
        if (pop_img) pending--;
        if (acc) outstanding++;
        if (fire) begin
            outstanding--;
            emitted++;
        end
        if (rst_s) outstanding = 0;
        sse_img_in_ready = ($urandom_range(0, 3) != 0);
        sse_select_ready = ($urandom_range(0, 2) == 0);
        img_in_valid     = (pending > 0) && ($urandom_range(0, 3) != 0);
        img_out_fire     = (outstanding > 0) && (emitted < budget) && ($urandom_range(0, 1) == 1);
        ack_full         = force_full || (rand_full && ($urandom_range(0, 3) == 0));
        refresh();
    endtask

    task automatic wait_acks(input int n, input int limit, input string name);
        int k = 0;
        while (ack_log.size() < n && k < limit) begin
            step();
            k++;
        end
        checks++;
        if (ack_log.size() < n) begin
            errors++;
            $display("FAIL %s timeout: acks seen %0d, required %0d", name, ack_log.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_q.push_back(8'h11);
        refresh();
        step();
        step();
        checks++;
        if (sse_reset !== 1'b1) begin
            errors++; $display("FAIL reset_sse_reset: got %b, required 1", sse_reset);
        end
        checks++;
        if ({cmd_rd_en, sse_select_valid, img_in_rd_en, sse_img_in_valid, ack_wr_en, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 000000",
                     {cmd_rd_en, sse_select_valid, img_in_rd_en, sse_img_in_valid, ack_wr_en, busy});
        end
        checks++;
        if (cur_select !== 8'h00) begin
            errors++; $display("FAIL reset_cur_select: got %h, required 00", cur_select);
        end
        cmd_q.delete();
        refresh();
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({sse_reset, busy} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle: got %b, required 00", {sse_reset, busy});
        end
        model_cfg = 1'b0;
        model_cur = 8'h00;
        clear_logs();
    endtask

    task automatic run_select_frame(input logic [7:0] sel, input string name);
        int base = pix_total;
        clear_logs();
        cmd_q.push_back(sel);
        pending += FP;
        refresh();
        wait_acks(1, 800, name);
        step();
        step();
        model_cfg = 1'b1;
        model_cur = sel;
        checks++;
        if (ack_log.size() != 1 || ack_log[0] !== sel) begin
            errors++; $display("FAIL %s_ack: got %h (n=%0d), required %h", name, ack_log[0], ack_log.size(), sel);
        end
        checks++;
        if (sel_log.size() != 1 || sel_log[0] !== sel) begin
            errors++; $display("FAIL %s_select: got %h (n=%0d), required %h", name, sel_log[0], sel_log.size(), sel);
        end
        checks++;
        if (cur_select !== model_cur || (pix_total - base) != FP || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_state: cur %h pix %0d busy %b, required cur %h pix %0d busy 0",
                     name, cur_select, pix_total - base, busy, model_cur, FP);
        end
    endtask

    task automatic test_select_frame();
        for (int i = 0; i < 3; i++)
            run_select_frame(8'($urandom_range(0, 254)), "select_frame");
    endtask

    task automatic expect_no_pass(input string name);
        int base = pix_total;
        int nack = ack_log.size();
        pending += 4;
        refresh();
        repeat (40) step();
        checks++;
        if (pix_total != base || ack_log.size() != nack || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_unconfigured: pops %0d acks %0d busy %b, required 0 0 0",
                     name, pix_total - base, ack_log.size() - nack, busy);
        end
        pending = 0;
        refresh();
    endtask

    task automatic test_reset_cmd();
        clear_logs();
        cmd_q.push_back(8'hFF);
        refresh();
        wait_acks(1, 200, "reset_cmd");
        step();
        step();
        model_cfg = 1'b0;
        checks++;
        if (ack_log.size() != 1 || ack_log[0] !== 8'hFF) begin
            errors++; $display("FAIL reset_cmd_ack: got %h (n=%0d), required ff", ack_log[0], ack_log.size());
        end
        checks++;
        if (pulse_log.size() != 1 || pulse_log[0] != RST) begin
            errors++; $display("FAIL reset_cmd_pulse: got %0d (n=%0d), required %0d", pulse_log[0], pulse_log.size(), RST);
        end
        expect_no_pass("reset_cmd");
    endtask

    task automatic test_auto_run();
        int base;
        run_select_frame(8'h05, "auto_setup");
        clear_logs();
        base = pix_total;
        pending += FP + 1;
        refresh();
        wait_acks(1, 800, "auto_run");
        checks++;
        if (ack_log[0] !== 8'h05 || sel_log.size() != 0) begin
            errors++; $display("FAIL auto_run_ack: got %h sel_n %0d, required 05 0", ack_log[0], sel_log.size());
        end
        checks++;
        if (pending_at_ack != 1 || (pix_total - base) != FP) begin
            errors++;
            $display("FAIL auto_run_hold: left %0d pops %0d, required 1 %0d", pending_at_ack, pix_total - base, FP);
        end
        pending += FP - 1;
        refresh();
        wait_acks(2, 800, "auto_run_2");
        step();
        step();
        checks++;
        if (ack_log[1] !== 8'h05 || pending != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL auto_run_second: ack %h left %0d busy %b, required 05 0 0", ack_log[1], pending, busy);
        end
    endtask

    task automatic test_cmd_mid_frame();
        int base = pix_total;
        int k = 0;
        clear_logs();
        pending += FP;
        refresh();
        while ((pix_total - base) < 5 && k < 400) begin
            step();
            k++;
        end
        checks++;
        if ((pix_total - base) < 5) begin
            errors++; $display("FAIL mid_frame_start: pops %0d, required 5", pix_total - base);
        end
        cmd_q.push_back(8'h07);
        refresh();
        wait_acks(1, 800, "mid_frame");
        checks++;
        if (ack_log[0] !== model_cur || cmd_pop_cyc.size() != 0) begin
            errors++; $display("FAIL mid_frame_ack: ack %h early_pops %0d, required %h 0", ack_log[0], cmd_pop_cyc.size(), model_cur);
        end
        step();
        step();
        step();
        checks++;
        if (cmd_pop_cyc.size() != 1 || cmd_pop_cyc[0] <= ack_cyc) begin
            errors++; $display("FAIL mid_frame_pop: pops %0d at %0d, required 1 after %0d", cmd_pop_cyc.size(), cmd_pop_cyc[0], ack_cyc);
        end
        pending += FP;
        refresh();
        wait_acks(2, 800, "mid_frame_next");
        step();
        model_cur = 8'h07;
        checks++;
        if (ack_log[1] !== 8'h07 || sel_log.size() != 1 || sel_log[0] !== 8'h07 || cur_select !== 8'h07) begin
            errors++;
            $display("FAIL mid_frame_next: ack %h sel %h cur %h, required 07 07 07", ack_log[1], sel_log[0], cur_select);
        end
    endtask

    task automatic test_ack_full();
        int base_e = emitted;
        int k = 0;
        clear_logs();
        force_full = 1'b1;
        ack_full   = 1'b1;
        pending += FP;
        refresh();
        while ((emitted - base_e) < FP && k < 800) begin
            step();
            k++;
        end
        checks++;
        if ((emitted - base_e) < FP) begin
            errors++; $display("FAIL ack_full_frame: outputs %0d, required %0d", emitted - base_e, FP);
        end
        repeat (10) step();
        checks++;
        if (ack_log.size() != 0 || ack_wr_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ack_full_hold: writes %0d wr_en %b busy %b, required 0 0 1", ack_log.size(), ack_wr_en, busy);
        end
        force_full = 1'b0;
        wait_acks(1, 50, "ack_full_release");
        repeat (5) step();
        checks++;
        if (ack_log.size() != 1 || ack_log[0] !== model_cur) begin
            errors++; $display("FAIL ack_full_write: got %h (n=%0d), required %h once", ack_log[0], ack_log.size(), model_cur);
        end
    endtask

    task automatic test_back_to_back();
        rand_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int kind = $urandom_range(0, 2);
            if (kind == 0) begin
                run_select_frame(8'($urandom_range(0, 254)), "b2b_select");
            end else if (kind == 1) begin
                clear_logs();
                cmd_q.push_back(8'hFF);
                refresh();
                wait_acks(1, 200, "b2b_reset");
                model_cfg = 1'b0;
                checks++;
                if (ack_log[0] !== 8'hFF) begin
                    errors++; $display("FAIL b2b_reset_ack: got %h, required ff", ack_log[0]);
                end
            end else if (model_cfg) begin
                clear_logs();
                pending += FP;
                refresh();
                wait_acks(1, 800, "b2b_frame");
                checks++;
                if (ack_log[0] !== model_cur) begin
                    errors++; $display("FAIL b2b_frame_ack: got %h, required %h", ack_log[0], model_cur);
                end
            end else begin
                expect_no_pass("b2b");
            end
        end
        rand_full = 1'b0;
        repeat (4) step();
    endtask

`ifdef SSE_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] sel = 8'($urandom_range(0, 254));
        clear_logs();
        budget = emitted + 10;
        cmd_q.push_back(sel);
        pending += FP;
        refresh();
        wait_acks(1, 1500, "timeout");
        budget = 32'h7fffffff;
        step();
        checks++;
        if (ack_log[0] !== 8'hEE || pulse_log.size() != 1 || pulse_log[0] != RST) begin
            errors++;
            $display("FAIL timeout_ack: ack %h pulses %0d len %0d, required ee 1 %0d", ack_log[0], pulse_log.size(), pulse_log[0], RST);
        end
        checks++;
        if ((rst_rise_cyc - last_pop_cyc) != TO + 1) begin
            errors++; $display("FAIL timeout_delay: got %0d, required %0d", rst_rise_cyc - last_pop_cyc, TO + 1);
        end
        model_cfg = 1'b0;
        expect_no_pass("timeout");
    endtask
`endif

    task automatic test_protocol();
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL protocol: violations %0d, required 0", viol);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; sse_select_ready = 1'b0;
        img_in_valid = 1'b0; sse_img_in_ready = 1'b0; img_out_fire = 1'b0; ack_full = 1'b0;
        pending = 0; outstanding = 0; emitted = 0; budget = 32'h7fffffff;
        pix_total = 0; cyc = 0; rst_run = 0; rst_rise_cyc = 0; last_pop_cyc = 0;
        ack_cyc = 0; pending_at_ack = 0; viol = 0; force_full = 1'b0; rand_full = 1'b0;
        rst_prev = 1'b0; model_cfg = 1'b0; model_cur = 8'h00;

        test_reset();
        test_select_frame();
        test_reset_cmd();
        test_auto_run();
        test_cmd_mid_frame();
        test_ack_full();
        test_back_to_back();
`ifdef SSE_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        test_protocol();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
